// File: rtl/arb_fifo_pair.sv
// arb_fifo_pair: two DEPTH-entry FIFOs merged by a round-robin arbiter into a
// single show-ahead valid/ready output stream.
// Optional feature macro: ARB_FIFO_DROP_CNT_EN adds saturating 8-bit counters
// of rejected pushes (drop_cnt0, drop_cnt1).
module arb_fifo_pair #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0,
  input  logic [WIDTH-1:0] data_in0,
  output logic             full0,
  output logic             empty0,
  input  logic             push1,
  input  logic [WIDTH-1:0] data_in1,
  output logic             full1,
  output logic             empty1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_src
`ifdef ARB_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt0,
  output logic [7:0]       drop_cnt1
`endif
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [1:0]       w_push_req;
  logic [WIDTH-1:0] w_din  [2];
  logic [WIDTH-1:0] w_head [2];
  logic [1:0]       w_full;
  logic [1:0]       w_empty;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic             w_grant;
  logic             w_valid;
  logic             w_fire;
  logic [WIDTH-1:0] w_data;
  logic             r_last_grant;

  assign w_push_req = {push1, push0};
  assign w_din[0]   = data_in0;
  assign w_din[1]   = data_in1;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_fifo
      logic [WIDTH-1:0]  r_mem [DEPTH];
      logic [ADDR_W-1:0] r_wr_ptr;
      logic [ADDR_W-1:0] r_rd_ptr;
      logic [ADDR_W:0]   r_cnt;

      // full/empty come only from the registered count
      assign w_full[g]  = (r_cnt == CNT_FULL);
      assign w_empty[g] = (r_cnt == CNT_ZERO);
      // a push into a full FIFO is dropped even if that FIFO pops this cycle
      assign w_push[g]  = w_push_req[g] & ~w_full[g];
      assign w_pop[g]   = w_fire & (w_grant == 1'(g));
      assign w_head[g]  = r_mem[r_rd_ptr];

      // storage write; contents are deliberately not reset
      always_ff @(posedge clk) begin
        if (w_push[g]) begin
          r_mem[r_wr_ptr] <= w_din[g];
        end
      end

      // pointer and occupancy bookkeeping
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_wr_ptr <= PTR_ZERO;
          r_rd_ptr <= PTR_ZERO;
          r_cnt    <= CNT_ZERO;
        end else begin
          if (w_push[g]) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
          end
          if (w_pop[g]) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
          end
          case ({w_push[g], w_pop[g]})
            2'b10:   r_cnt <= r_cnt + CNT_ONE;
            2'b01:   r_cnt <= r_cnt - CNT_ONE;
            default: r_cnt <= r_cnt;
          endcase
        end
      end

`ifdef ARB_FIFO_DROP_CNT_EN
      logic [7:0] r_drop_cnt;

      // saturating count of pushes rejected because the FIFO was full
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_drop_cnt <= 8'h00;
        end else if (w_push_req[g] && w_full[g] && (r_drop_cnt != 8'hFF)) begin
          r_drop_cnt <= r_drop_cnt + 8'h01;
        end
      end
`endif
    end
  endgenerate

`ifdef ARB_FIFO_DROP_CNT_EN
  assign drop_cnt0 = g_fifo[0].r_drop_cnt;
  assign drop_cnt1 = g_fifo[1].r_drop_cnt;
`endif

  // round-robin grant from registered state; alternates only when both hold data
  always_comb begin
    w_grant = 1'b0;
    if (!w_empty[0] && !w_empty[1]) begin
      w_grant = ~r_last_grant;
    end else if (!w_empty[1]) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  assign w_valid = ~(w_empty[0] & w_empty[1]);
  assign w_fire  = w_valid & out_ready;

  // show-ahead output mux, forced to zero when nothing is valid
  always_comb begin
    w_data = {WIDTH{1'b0}};
    if (!w_valid) begin
      w_data = {WIDTH{1'b0}};
    end else if (w_grant) begin
      w_data = w_head[1];
    end else begin
      w_data = w_head[0];
    end
  end

  // remember which FIFO was served last; updated only on an accepted pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
    end else if (w_fire) begin
      r_last_grant <= w_grant;
    end
  end

  assign full0     = w_full[0];
  assign empty0    = w_empty[0];
  assign full1     = w_full[1];
  assign empty1    = w_empty[1];
  assign out_valid = w_valid;
  assign data_out  = w_data;
  assign out_src   = w_valid & w_grant;

endmodule
